// File: rtl/mac_pkg.sv
// Shared types and default sizes for the multiply-accumulate datapath.
package mac_pkg;

    localparam int unsigned DEF_PROD_W    = 16;
    localparam int unsigned DEF_ACC_W     = 20;
    localparam int unsigned DEF_MAX_TERMS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder of a wide operand and a zero-extended narrow one, saturating to all ones.
module sat_adder #(
    parameter int unsigned A_W = 20,
    parameter int unsigned B_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           ovf
);

    logic [A_W:0] full;

    // One extra bit holds the carry-out that signals saturation.
    assign full = {1'b0, a} + (A_W+1)'(b);
    assign ovf  = full[A_W];
    assign sum  = ovf ? '1 : full[A_W-1:0];

endmodule

// File: rtl/mult_accumulator.sv
// Sums a group of multiplier products into a saturating accumulator and
// presents the group result over a valid/ready handshake.
module mult_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W    = DEF_PROD_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS,
    parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    acc_state_t        state;
    acc_state_t        state_next;
    logic              accept;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic [CNT_W-1:0]  cnt_inc;
    logic              at_max;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;

    assign in_ready = (state != DONE);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = term_cnt + CNT_W'(1);
    assign at_max   = (cnt_inc == CNT_W'(MAX_TERMS));

    sat_adder #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_adder (
        .a   (acc_out),
        .b   (in_prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear wins over any beat or handshake
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = (in_last || MAX_TERMS == 1) ? DONE : ACC;
                ACC:  if (accept) state_next = (in_last || at_max) ? DONE : ACC;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath next values: first beat loads, later beats add, otherwise hold
    always_comb begin
        acc_next = acc_out;
        cnt_next = term_cnt;
        ovf_next = ovf;
        if (clear) begin
            acc_next = '0;
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (accept && state == IDLE) begin
            acc_next = ACC_W'(in_prod);
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
        end else if (accept && state == ACC) begin
            acc_next = add_sum;
            cnt_next = cnt_inc;
            ovf_next = ovf | add_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            term_cnt  <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc_out   <= acc_next;
            term_cnt  <= cnt_next;
            ovf       <= ovf_next;
            out_valid <= (state_next == DONE);
        end
    end

endmodule
